// File: rtl/seq_shift_unit_pkg.sv
// Shared types and encodings for the iterative shifter and its step helper.
package seq_shift_unit_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam logic SH_LEFT  = 1'b1;
  localparam logic SH_RIGHT = 1'b0;
  localparam logic SH_ARITH = 1'b1;
  localparam logic SH_LOGIC = 1'b0;

endpackage

// File: rtl/seq_shift_unit_shift_step.sv
// Combinational shift by k (0..STEP); left fills zeros, right fills with the given fill bit.
module shift_step
  import seq_shift_unit_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int STEP  = 1,
  parameter int KW    = $clog2(STEP + 1)
) (
  input  logic [WIDTH-1:0] data,
  input  logic [KW-1:0]    k,
  input  logic             l_or_r,
  input  logic             fill,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] lcand [STEP+1];
  logic [WIDTH-1:0] rcand [STEP+1];

  assign lcand[0] = data;
  assign rcand[0] = data;

  for (genvar i = 1; i <= STEP; i++) begin : g_cand
    assign lcand[i] = {data[WIDTH-1-i:0], {i{1'b0}}};
    assign rcand[i] = {{i{fill}}, data[WIDTH-1:i]};
  end

  always_comb begin
    q = data;
    for (int j = 0; j <= STEP; j++) begin
      if (k == KW'(j)) q = (l_or_r == SH_LEFT) ? lcand[j] : rcand[j];
    end
  end

endmodule

// File: rtl/seq_shift_unit.sv
// Multi-cycle shifter: accepts one request, shifts up to STEP bits per cycle,
// then holds the result until the consumer takes it.
module seq_shift_unit
  import seq_shift_unit_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int STEP  = 1,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [SHW-1:0]   in_shamt,
  input  logic             in_l_or_r,
  input  logic             in_a_or_l,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_q,
  output logic             busy
);

  localparam int KW = $clog2(STEP + 1);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] data_r;
  logic [SHW-1:0]   cnt;
  logic [SHW-1:0]   cnt_next;
  logic [KW-1:0]    k;
  logic             l_or_r_r;
  logic             fill_r;
  logic [WIDTH-1:0] step_q;
  logic             accept;
  logic             step_en;

  // Remaining amount may exceed STEP; clamp the per-cycle shift.
  assign k        = (cnt < SHW'(STEP)) ? cnt[KW-1:0] : KW'(STEP);
  assign cnt_next = cnt - SHW'(k);

  shift_step #(
    .WIDTH(WIDTH),
    .STEP (STEP)
  ) u_step (
    .data  (data_r),
    .k     (k),
    .l_or_r(l_or_r_r),
    .fill  (fill_r),
    .q     (step_q)
  );

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    step_en = 1'b0;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          accept  = 1'b1;
          state_d = (in_shamt == '0) ? DONE : SHIFT;
        end
      end
      SHIFT: begin
        step_en = 1'b1;
        if (cnt_next == '0) state_d = DONE;
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign busy      = (state_q != IDLE);

  // Fill bit is frozen at acceptance so later steps never re-derive it.
  always_ff @(posedge clk) begin
    if (rst) begin
      data_r   <= '0;
      cnt      <= '0;
      l_or_r_r <= 1'b0;
      fill_r   <= 1'b0;
      out_q    <= '0;
    end else if (accept) begin
      data_r   <= in_data;
      cnt      <= in_shamt;
      l_or_r_r <= in_l_or_r;
      fill_r   <= in_data[WIDTH-1] & (in_a_or_l == SH_ARITH) & (in_l_or_r == SH_RIGHT);
      if (in_shamt == '0) out_q <= in_data;
    end else if (step_en) begin
      data_r <= step_q;
      cnt    <= cnt_next;
      if (cnt_next == '0) out_q <= step_q;
    end
  end

endmodule

// File: tb/tb_seq_shift_unit.sv
// Directed bench for seq_shift_unit (STEP=1 and STEP=4 instances) against a transaction-level model.
module tb_seq_shift_unit;
  import seq_shift_unit_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid  [2];
  logic        in_ready  [2];
  logic [31:0] in_data   [2];
  logic [4:0]  in_shamt  [2];
  logic        in_l_or_r [2];
  logic        in_a_or_l [2];
  logic        out_valid [2];
  logic        out_ready [2];
  logic [31:0] out_q     [2];
  logic        busy      [2];

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 2; g++) begin : g_dut
    seq_shift_unit #(.WIDTH(32), .STEP(g == 0 ? 1 : 4)) u_dut (
      .clk      (clk),
      .rst      (rst),
      .in_valid (in_valid[g]),
      .in_ready (in_ready[g]),
      .in_data  (in_data[g]),
      .in_shamt (in_shamt[g]),
      .in_l_or_r(in_l_or_r[g]),
      .in_a_or_l(in_a_or_l[g]),
      .out_valid(out_valid[g]),
      .out_ready(out_ready[g]),
      .out_q    (out_q[g]),
      .busy     (busy[g])
    );
  end

  function automatic int step_of(int i);
    return (i == 0) ? 1 : 4;
  endfunction

  function automatic logic [31:0] ref_shift(logic [31:0] d, int sh, logic lr, logic al);
    if (lr == SH_LEFT) return d << sh;
    if (al == SH_ARITH) return 32'($signed(d) >>> sh);
    return d >> sh;
  endfunction

  // Model: 0 = waiting for request, 1 = working (m_left cycles to go), 2 = result held
  int          m_state [2] = '{0, 0};
  int          m_left  [2] = '{0, 0};
  logic [31:0] m_res   [2] = '{32'h0, 32'h0};
  logic [31:0] m_q     [2] = '{32'h0, 32'h0};

  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (rst) begin
        m_state[i] <= 0;
        m_left[i]  <= 0;
        m_q[i]     <= 32'h0;
      end else begin
        case (m_state[i])
          0: if (in_valid[i]) begin
            m_res[i] <= ref_shift(in_data[i], int'(in_shamt[i]), in_l_or_r[i], in_a_or_l[i]);
            if (in_shamt[i] == 5'd0) begin
              m_state[i] <= 2;
              m_q[i]     <= in_data[i];
            end else begin
              m_state[i] <= 1;
              m_left[i]  <= (int'(in_shamt[i]) + step_of(i) - 1) / step_of(i);
            end
          end
          1: if (m_left[i] == 1) begin
            m_state[i] <= 2;
            m_q[i]     <= m_res[i];
          end else begin
            m_left[i] <= m_left[i] - 1;
          end
          default: if (out_ready[i]) m_state[i] <= 0;
        endcase
      end
    end
  end

  task automatic chk(string name, int i, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s dut%0d: got %h expected %h at %0t", name, i, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      for (int i = 0; i < 2; i++) begin
        chk("model in_ready", i, 32'(in_ready[i]), 32'(m_state[i] == 0));
        chk("model busy", i, 32'(busy[i]), 32'(m_state[i] != 0));
        chk("model out_valid", i, 32'(out_valid[i]), 32'(m_state[i] == 2));
        chk("model out_q", i, out_q[i], m_q[i]);
      end
    end
  end

  // Called at a negedge; returns at the negedge where out_valid is first seen.
  task automatic run_op(int i, logic [31:0] d, logic [4:0] sh, logic lr, logic al,
                        logic [31:0] exp_q, int exp_lat, string name);
    int lat;
    bit ok;
    in_valid[i]  = 1'b1;
    in_data[i]   = d;
    in_shamt[i]  = sh;
    in_l_or_r[i] = lr;
    in_a_or_l[i] = al;
    ok = 1'b0;
    for (int t = 0; t < 200; t++) begin
      if (in_ready[i]) begin ok = 1'b1; break; end
      @(negedge clk);
    end
    chk({name, " accept"}, i, 32'(ok), 32'd1);
    @(negedge clk);
    in_valid[i]  = 1'b0;
    in_data[i]   = ~d;
    in_shamt[i]  = ~sh;
    in_l_or_r[i] = ~lr;
    lat = 1;
    ok  = 1'b0;
    for (int t = 0; t < 200; t++) begin
      if (out_valid[i]) begin ok = 1'b1; break; end
      @(negedge clk);
      lat++;
    end
    chk({name, " done"}, i, 32'(ok), 32'd1);
    chk({name, " latency"}, i, 32'(lat), 32'(exp_lat));
    chk({name, " q"}, i, out_q[i], exp_q);
  endtask

  task automatic take(int i);
    out_ready[i] = 1'b1;
    @(negedge clk);
    out_ready[i] = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, expected finish before %0t", $time);
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    for (int i = 0; i < 2; i++) begin
      in_valid[i]  = 1'b0;
      in_data[i]   = 32'h0;
      in_shamt[i]  = 5'd0;
      in_l_or_r[i] = 1'b0;
      in_a_or_l[i] = 1'b0;
      out_ready[i] = 1'b0;
    end
    repeat (3) @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      chk("reset in_ready", i, 32'(in_ready[i]), 32'd1);
      chk("reset out_valid", i, 32'(out_valid[i]), 32'd0);
      chk("reset out_q", i, out_q[i], 32'h0);
      chk("reset busy", i, 32'(busy[i]), 32'd0);
    end
    rst    = 1'b0;
    chk_en = 1'b1;
    @(negedge clk);

    run_op(0, 32'h8000_0000, 5'd4, SH_RIGHT, SH_ARITH, 32'hF800_0000, 5, "sra4");
    take(0);
    run_op(0, 32'h0000_0001, 5'd31, SH_LEFT, SH_LOGIC, 32'h8000_0000, 32, "sll31");
    take(0);
    run_op(0, 32'hF000_0000, 5'd0, SH_RIGHT, SH_LOGIC, 32'hF000_0000, 1, "srl0");
    take(0);

    run_op(1, 32'hFFFF_FFFF, 5'd9, SH_RIGHT, SH_LOGIC, 32'h007F_FFFF, 4, "s4 srl9");
    take(1);
    run_op(1, 32'h7FFF_FFFF, 5'd9, SH_RIGHT, SH_ARITH, 32'h003F_FFFF, 4, "s4 sra9");
    take(1);
    run_op(1, 32'h8000_0000, 5'd31, SH_RIGHT, SH_ARITH, 32'hFFFF_FFFF, 9, "s4 sra31");
    take(1);
    run_op(1, 32'hFFFF_FFFF, 5'd31, SH_LEFT, SH_LOGIC, 32'h8000_0000, 9, "s4 sll31");
    take(1);

    // Backpressure: result must hold while new requests are waved at a busy unit
    run_op(0, 32'h0000_1234, 5'd3, SH_LEFT, SH_LOGIC, 32'h0000_91A0, 4, "bp sll3");
    for (int t = 0; t < 3; t++) begin
      in_valid[0] = 1'b1;
      in_data[0]  = 32'hDEAD_0000 + 32'(t);
      in_shamt[0] = 5'(t + 1);
      @(negedge clk);
      chk("bp in_ready", 0, 32'(in_ready[0]), 32'd0);
      chk("bp out_valid", 0, 32'(out_valid[0]), 32'd1);
      chk("bp out_q", 0, out_q[0], 32'h0000_91A0);
    end
    in_data[0]   = 32'h0000_00F0;
    in_shamt[0]  = 5'd4;
    in_l_or_r[0] = SH_RIGHT;
    in_a_or_l[0] = SH_LOGIC;
    take(0);
    chk("bp release in_ready", 0, 32'(in_ready[0]), 32'd1);
    chk("bp release out_valid", 0, 32'(out_valid[0]), 32'd0);
    run_op(0, 32'h0000_00F0, 5'd4, SH_RIGHT, SH_LOGIC, 32'h0000_000F, 5, "bp next");
    take(0);

    // Reset in the middle of a long shift
    in_valid[0]  = 1'b1;
    in_data[0]   = 32'h0000_FFFF;
    in_shamt[0]  = 5'd20;
    in_l_or_r[0] = SH_LEFT;
    @(negedge clk);
    in_valid[0] = 1'b0;
    repeat (6) @(negedge clk);
    chk("mid busy", 0, 32'(busy[0]), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("rst in_ready", 0, 32'(in_ready[0]), 32'd1);
    chk("rst out_valid", 0, 32'(out_valid[0]), 32'd0);
    chk("rst out_q", 0, out_q[0], 32'h0);
    chk("rst busy", 0, 32'(busy[0]), 32'd0);
    run_op(0, 32'h0000_0003, 5'd2, SH_LEFT, SH_LOGIC, 32'h0000_000C, 3, "post rst sll2");
    take(0);

    // Reset coinciding with the output handshake
    run_op(1, 32'h0000_0100, 5'd4, SH_RIGHT, SH_LOGIC, 32'h0000_0010, 2, "s4 srl4");
    out_ready[1] = 1'b1;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    out_ready[1] = 1'b0;
    chk("rst+hs out_q", 1, out_q[1], 32'h0);
    chk("rst+hs in_ready", 1, 32'(in_ready[1]), 32'd1);
    for (int t = 0; t < 4; t++) begin
      chk("rst+hs out_valid", 1, 32'(out_valid[1]), 32'd0);
      @(negedge clk);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
